// File: rtl/float_accumulator.sv
// float_accumulator
//    Multi-cycle IEEE-754 single-precision adder that folds a stream of
//    operands into a running accumulator. Each add walks IDLE -> ALIGN ->
//    ADD -> NORM (one shift per cycle) -> DONE. Zero and denormal values
//    count as +0. Denormal results are flushed to +0. Exponent overflow
//    saturates to infinity. An infinite accumulator stays fixed until it is
//    cleared.
// Ports
//    clk         rising-edge clock
//    rst         synchronous active-high reset
//    clear       synchronous accumulator clear / abort of an add in flight
//    in_valid    operand valid
//    in_ready    block can take an operand this cycle
//    in_float    operand {sign, exp, mantissa}
//    acc_result  registered running sum
//    busy        high whenever the FSM is not idle
//    done        one-cycle pulse after acc_result has been updated
module float_accumulator #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [EXP_W+MAN_W:0]     in_float,
   output logic [EXP_W+MAN_W:0]     acc_result,
   output logic                     busy,
   output logic                     done
);

   localparam int W  = 1 + EXP_W + MAN_W;
   localparam int MW = MAN_W + 1;

   typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;

   state_t             state, nextState;
   logic [W-1:0]       opnd;
   logic [MW-1:0]      mantBig, mantSmall;
   logic               signBig, signSmall;
   logic [MW:0]        sum;
   logic [EXP_W-1:0]   expReg;
   logic               signReg;
   logic               special;
   logic [W-1:0]       specialVal;

   // Operand views used by the ALIGN step; exp==0 means +0.
   logic [EXP_W-1:0]   expA, expB, expDiff;
   logic [MW-1:0]      manA, manB, shiftedSmall;
   logic               signA, signB, aBigger;

   // Outcome of the current NORM cycle.
   logic               normFinish;
   logic [W-1:0]       normResult;

   assign in_ready = (state == IDLE) && !clear && !rst;
   assign busy     = (state != IDLE);
   assign done     = (state == DONE);

   // Unpack accumulator and latched operand, pick the larger exponent and
   // right-shift the other mantissa, dropping bits that fall off the end.
   always_comb begin
      expA    = acc_result[W-2 -: EXP_W];
      expB    = opnd[W-2 -: EXP_W];
      manA    = (expA == '0) ? '0 : {1'b1, acc_result[MAN_W-1:0]};
      manB    = (expB == '0) ? '0 : {1'b1, opnd[MAN_W-1:0]};
      signA   = (expA == '0) ? 1'b0 : acc_result[W-1];
      signB   = (expB == '0) ? 1'b0 : opnd[W-1];
      aBigger = (expA >= expB);
      expDiff = aBigger ? (expA - expB) : (expB - expA);
      shiftedSmall = '0;
      if (expDiff < EXP_W'(MW))
         shiftedSmall = (aBigger ? manB : manA) >> expDiff;
   end

   // Next-state logic plus the one-step normaliser decision.
   always_comb begin
      nextState  = state;
      normFinish = 1'b0;
      normResult = '0;
      case (state)
         IDLE:  if (in_valid && in_ready) nextState = ALIGN;
         ALIGN: nextState = ADD;
         ADD:   nextState = NORM;
         NORM: begin
            if (special) begin
               normFinish = 1'b1;
               normResult = specialVal;
            end else if (sum == '0) begin
               normFinish = 1'b1;
            end else if (sum[MW]) begin
               // Carry out: the increment landing on all-ones is overflow.
               if (expReg == {{(EXP_W-1){1'b1}}, 1'b0}) begin
                  normFinish = 1'b1;
                  normResult = {signReg, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
               end
            end else if (!sum[MW-1]) begin
               // A left shift that would reach exp 0 would make a denormal.
               if (expReg == EXP_W'(1))
                  normFinish = 1'b1;
            end else begin
               normFinish = 1'b1;
               normResult = {signReg, expReg, sum[MAN_W-1:0]};
            end
            if (normFinish) nextState = DONE;
         end
         DONE:    nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // State register and datapath; rst outranks clear, clear outranks all else.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         state      <= IDLE;
         acc_result <= '0;
         opnd       <= '0;
         mantBig    <= '0;
         mantSmall  <= '0;
         signBig    <= 1'b0;
         signSmall  <= 1'b0;
         sum        <= '0;
         expReg     <= '0;
         signReg    <= 1'b0;
         special    <= 1'b0;
         specialVal <= '0;
      end else begin
         state <= nextState;
         case (state)
            IDLE: if (in_valid && in_ready) opnd <= in_float;
            ALIGN: begin
               mantBig   <= aBigger ? manA : manB;
               mantSmall <= shiftedSmall;
               signBig   <= aBigger ? signA : signB;
               signSmall <= aBigger ? signB : signA;
               expReg    <= aBigger ? expA : expB;
               // Infinite accumulator sticks; an infinite operand takes over.
               special    <= 1'b0;
               specialVal <= '0;
               if (expA == '1) begin
                  special    <= 1'b1;
                  specialVal <= acc_result;
               end else if (expB == '1) begin
                  special    <= 1'b1;
                  specialVal <= {opnd[W-1], {EXP_W{1'b1}}, {MAN_W{1'b0}}};
               end
            end
            ADD: begin
               if (signBig == signSmall) begin
                  sum     <= {1'b0, mantBig} + {1'b0, mantSmall};
                  signReg <= signBig;
               end else if (mantBig > mantSmall) begin
                  sum     <= {1'b0, mantBig} - {1'b0, mantSmall};
                  signReg <= signBig;
               end else if (mantBig < mantSmall) begin
                  sum     <= {1'b0, mantSmall} - {1'b0, mantBig};
                  signReg <= signSmall;
               end else begin
                  sum     <= '0;
                  signReg <= 1'b0;
               end
            end
            NORM: begin
               if (normFinish) begin
                  acc_result <= normResult;
               end else if (sum[MW]) begin
                  sum    <= sum >> 1;
                  expReg <= expReg + EXP_W'(1);
               end else begin
                  sum    <= sum << 1;
                  expReg <= expReg - EXP_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule
